// File: rtl/sc_regshift_player_pkg.sv
// Shared definitions for the player position datapath and the player state machines.
// Holds the shift-selection command codes and the default register geometry.
package sc_regshift_player_pkg;

    typedef enum logic [1:0] {
        SHIFTSEL_NOP   = 2'b00,
        SHIFTSEL_LEFT  = 2'b01,
        SHIFTSEL_RIGHT = 2'b10,
        SHIFTSEL_HOLD  = 2'b11
    } shiftsel_e;

    localparam int          DEFAULT_DATAWIDTH = 8;
    localparam logic [7:0]  DEFAULT_INIT_POS  = 8'b0001_0000;

endpackage

// File: rtl/sc_regshift_player_onehot_check.sv
// Combinational one-hot validity check with edge-bit flags.
// Shared by the player and opponent position registers.
module sc_onehot_check #(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0] data_i,
    output logic                 valid_o,
    output logic                 msb_o,
    output logic                 lsb_o
);

    // x & (x-1) clears the lowest set bit; zero result with nonzero x means exactly one bit.
    logic [DATAWIDTH-1:0] low_cleared;

    assign low_cleared = data_i & (data_i - DATAWIDTH'(1));
    assign valid_o     = (data_i != '0) && (low_cleared == '0);
    assign msb_o       = data_i[DATAWIDTH-1];
    assign lsb_o       = data_i[0];

endmodule

// File: rtl/sc_regshift_player.sv
// Player position register: executes clear/load/shift commands on a one-hot position,
// reporting validity, edge flags, a blocked-shift bump pulse and a wrapping move count.
module sc_regshift_player
    import sc_regshift_player_pkg::*;
#(
    parameter int                   DATAWIDTH       = DEFAULT_DATAWIDTH,
    parameter logic [DATAWIDTH-1:0] INIT_POS        = DATAWIDTH'(DEFAULT_INIT_POS),
    parameter int                   MOVECOUNT_WIDTH = 4
) (
    input  logic                       SC_REGSHIFT_PLAYER_CLOCK_50,
    input  logic                       SC_REGSHIFT_PLAYER_RESET_InHigh,
    input  logic                       SC_REGSHIFT_PLAYER_clear_InLow,
    input  logic                       SC_REGSHIFT_PLAYER_load0_InLow,
    input  logic                       SC_REGSHIFT_PLAYER_load1_InLow,
    input  logic [1:0]                 SC_REGSHIFT_PLAYER_shiftselection_In,
    input  logic [DATAWIDTH-1:0]       SC_REGSHIFT_PLAYER_data0_In,
    input  logic [DATAWIDTH-1:0]       SC_REGSHIFT_PLAYER_data1_In,
    output logic [DATAWIDTH-1:0]       SC_REGSHIFT_PLAYER_data_Out,
    output logic                       SC_REGSHIFT_PLAYER_sidecomparator_OutLow,
    output logic                       SC_REGSHIFT_PLAYER_atLeft_OutLow,
    output logic                       SC_REGSHIFT_PLAYER_atRight_OutLow,
    output logic                       SC_REGSHIFT_PLAYER_bump_OutLow,
    output logic [MOVECOUNT_WIDTH-1:0] SC_REGSHIFT_PLAYER_movecount_Out
);

    logic [DATAWIDTH-1:0]       data_q, data_d;
    logic [MOVECOUNT_WIDTH-1:0] count_q, count_d;
    logic                       bump_q, bump_d;
    logic                       pos_valid, pos_msb, pos_lsb;
    shiftsel_e                  shift_sel;

    sc_onehot_check #(
        .DATAWIDTH(DATAWIDTH)
    ) u_onehot_check (
        .data_i  (data_q),
        .valid_o (pos_valid),
        .msb_o   (pos_msb),
        .lsb_o   (pos_lsb)
    );

    assign shift_sel = shiftsel_e'(SC_REGSHIFT_PLAYER_shiftselection_In);

    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        bump_d  = 1'b1;
        if (!SC_REGSHIFT_PLAYER_clear_InLow) begin
            data_d  = INIT_POS;
            count_d = '0;
        end else if (!SC_REGSHIFT_PLAYER_load0_InLow) begin
            data_d = SC_REGSHIFT_PLAYER_data0_In;
        end else if (!SC_REGSHIFT_PLAYER_load1_InLow) begin
            data_d = SC_REGSHIFT_PLAYER_data1_In;
        end else if (pos_valid) begin
            // An invalid register silently ignores shifts: no move, no count, no bump.
            case (shift_sel)
                SHIFTSEL_LEFT: begin
                    if (pos_msb) begin
                        bump_d = 1'b0;
                    end else begin
                        data_d  = data_q << 1;
                        count_d = count_q + MOVECOUNT_WIDTH'(1);
                    end
                end
                SHIFTSEL_RIGHT: begin
                    if (pos_lsb) begin
                        bump_d = 1'b0;
                    end else begin
                        data_d  = data_q >> 1;
                        count_d = count_q + MOVECOUNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge SC_REGSHIFT_PLAYER_CLOCK_50) begin
        if (SC_REGSHIFT_PLAYER_RESET_InHigh) begin
            data_q  <= INIT_POS;
            count_q <= '0;
            bump_q  <= 1'b1;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
            bump_q  <= bump_d;
        end
    end

    assign SC_REGSHIFT_PLAYER_data_Out              = data_q;
    assign SC_REGSHIFT_PLAYER_sidecomparator_OutLow = pos_valid;
    assign SC_REGSHIFT_PLAYER_atLeft_OutLow         = ~pos_msb;
    assign SC_REGSHIFT_PLAYER_atRight_OutLow        = ~pos_lsb;
    assign SC_REGSHIFT_PLAYER_bump_OutLow           = bump_q;
    assign SC_REGSHIFT_PLAYER_movecount_Out         = count_q;

endmodule

// File: tb/tb_sc_regshift_player.sv
// Self-checking bench for sc_regshift_player: directed scenarios with literal expectations,
// then randomized commands compared every cycle against a behavioural model.
module tb_sc_regshift_player;

    logic       clk;
    logic       rst;
    logic       clr_n;
    logic       ld0_n;
    logic       ld1_n;
    logic [1:0] sh;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] data_o;
    logic       side_o;
    logic       atl_o;
    logic       atr_o;
    logic       bump_o;
    logic [3:0] cnt_o;

    int passed = 0;
    int total  = 0;

    sc_regshift_player dut (
        .SC_REGSHIFT_PLAYER_CLOCK_50              (clk),
        .SC_REGSHIFT_PLAYER_RESET_InHigh          (rst),
        .SC_REGSHIFT_PLAYER_clear_InLow           (clr_n),
        .SC_REGSHIFT_PLAYER_load0_InLow           (ld0_n),
        .SC_REGSHIFT_PLAYER_load1_InLow           (ld1_n),
        .SC_REGSHIFT_PLAYER_shiftselection_In     (sh),
        .SC_REGSHIFT_PLAYER_data0_In              (d0),
        .SC_REGSHIFT_PLAYER_data1_In              (d1),
        .SC_REGSHIFT_PLAYER_data_Out              (data_o),
        .SC_REGSHIFT_PLAYER_sidecomparator_OutLow (side_o),
        .SC_REGSHIFT_PLAYER_atLeft_OutLow         (atl_o),
        .SC_REGSHIFT_PLAYER_atRight_OutLow        (atr_o),
        .SC_REGSHIFT_PLAYER_bump_OutLow           (bump_o),
        .SC_REGSHIFT_PLAYER_movecount_Out         (cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: position as an integer, moves as *2 and /2, count modulo 16.
    int  m_pos;
    int  m_cnt;
    int  m_bump;
    bit  model_ok = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_pos = 16; m_cnt = 0; m_bump = 1; model_ok = 1;
        end else if (model_ok) begin
            m_bump = 1;
            if (!clr_n) begin
                m_pos = 16; m_cnt = 0;
            end else if (!ld0_n) begin
                m_pos = int'(d0);
            end else if (!ld1_n) begin
                m_pos = int'(d1);
            end else if ($countones(m_pos) == 1) begin
                if (sh == 2'b01) begin
                    if (m_pos == 128) m_bump = 0;
                    else begin m_pos = m_pos * 2; m_cnt = (m_cnt + 1) % 16; end
                end else if (sh == 2'b10) begin
                    if (m_pos == 1) m_bump = 0;
                    else begin m_pos = m_pos / 2; m_cnt = (m_cnt + 1) % 16; end
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("model_data",  int'(data_o), m_pos);
            chk("model_cnt",   int'(cnt_o),  m_cnt);
            chk("model_bump",  int'(bump_o), m_bump);
            chk("model_side",  int'(side_o), ($countones(m_pos) == 1) ? 1 : 0);
            chk("model_atl",   int'(atl_o),  (m_pos >= 128) ? 0 : 1);
            chk("model_atr",   int'(atr_o),  (m_pos % 2 == 1) ? 0 : 1);
        end
    end

    // Drive one cycle's command (inputs change on negedge, sampled at the next posedge).
    task automatic cyc(input logic r, input logic c, input logic l0, input logic l1,
                       input logic [1:0] s, input logic [7:0] a, input logic [7:0] b);
        rst = r; clr_n = c; ld0_n = l0; ld1_n = l1; sh = s; d0 = a; d1 = b;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 8'h00, 8'h00);
    endtask

    task automatic shift(input logic [1:0] s);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, s, 8'h00, 8'h00);
    endtask

    logic [7:0] exp_walk [5];
    logic       exp_atl  [5];
    logic       exp_bump [5];

    initial begin
        exp_walk = '{8'h20, 8'h40, 8'h80, 8'h80, 8'h80};
        exp_atl  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_bump = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; clr_n = 1'b1; ld0_n = 1'b1; ld1_n = 1'b1; sh = 2'b11; d0 = '0; d1 = '0;
        @(negedge clk);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 8'h00, 8'h00);
        chk("reset_data", int'(data_o), 'h10);
        chk("reset_cnt",  int'(cnt_o),  0);
        chk("reset_side", int'(side_o), 1);
        chk("reset_bump", int'(bump_o), 1);
        shift(2'b01);
        chk("first_shift_data", int'(data_o), 'h20);
        chk("first_shift_cnt",  int'(cnt_o),  1);

        // Left walk into the MSB edge.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) begin
            shift(2'b01);
            chk("walkL_data", int'(data_o), int'(exp_walk[i]));
            chk("walkL_atl",  int'(atl_o),  int'(exp_atl[i]));
            chk("walkL_bump", int'(bump_o), int'(exp_bump[i]));
        end
        chk("walkL_cnt", int'(cnt_o), 3);
        idle();
        chk("bump_release", int'(bump_o), 1);

        // Right walk into the LSB edge.
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 8'h02, 8'h00);
        chk("load_keeps_cnt", int'(cnt_o), 3);
        for (int i = 0; i < 3; i++) begin
            shift(2'b10);
            chk("walkR_data", int'(data_o), 'h01);
            chk("walkR_bump", int'(bump_o), (i == 0) ? 1 : 0);
        end
        chk("walkR_cnt", int'(cnt_o), 4);
        chk("walkR_atr", int'(atr_o), 0);

        // Invalid load blocks shifts until cleared.
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 8'h24, 8'h00);
        chk("inv_data", int'(data_o), 'h24);
        chk("inv_side", int'(side_o), 0);
        shift(2'b01);
        chk("inv_shift_data", int'(data_o), 'h24);
        chk("inv_shift_cnt",  int'(cnt_o),  4);
        chk("inv_shift_bump", int'(bump_o), 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 8'h00, 8'h00);
        chk("clr_data", int'(data_o), 'h10);
        chk("clr_side", int'(side_o), 1);
        chk("clr_cnt",  int'(cnt_o),  0);

        // Command priority.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 8'h04, 8'h40);
        chk("prio_clear", int'(data_o), 'h10);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 8'h04, 8'h40);
        chk("prio_load0", int'(data_o), 'h04);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 8'h04, 8'h40);
        chk("prio_load1", int'(data_o), 'h40);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 8'h04, 8'h00);

        // Counter wrap after 16 valid moves.
        for (int i = 0; i < 16; i++) shift((i % 2 == 0) ? 2'b01 : 2'b10);
        chk("wrap_cnt",  int'(cnt_o),  0);
        chk("wrap_data", int'(data_o), 'h04);

        // Reset mid-burst.
        shift(2'b01);
        shift(2'b01);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 8'h00, 8'h00);
        chk("midrst_data", int'(data_o), 'h10);
        chk("midrst_cnt",  int'(cnt_o),  0);
        chk("midrst_bump", int'(bump_o), 1);

        // Randomized commands against the model.
        for (int i = 0; i < 3000; i++) begin
            logic       r, c, l0, l1;
            logic [7:0] a, b;
            r  = ($urandom_range(0, 99) == 0);
            c  = ($urandom_range(0, 19) != 0);
            l0 = ($urandom_range(0, 11) != 0);
            l1 = ($urandom_range(0, 11) != 0);
            a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (8'h01 << $urandom_range(0, 7));
            b  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (8'h01 << $urandom_range(0, 7));
            cyc(r, c, l0, l1, 2'($urandom_range(0, 3)), a, b);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sc_regshift_player.md
Name: sc_regshift_player

Overview:
- Player-position datapath that executes the command word issued by the player state machine: clear, load0, load1 and shiftselection.
- Holds a one-hot position register and moves it left or right on command.
- Returns the active-low side-comparator status that gates moves in the state machine.
- Also reports edge flags, a single-cycle bump pulse and a move counter to the display/scoring logic.

Parameters:
- DATAWIDTH, 8, width of the one-hot position register.
- INIT_POS, 8'b0001_0000, position loaded on reset and on clear.
- MOVECOUNT_WIDTH, 4, width of the move counter (wraps).

Ports:
- SC_REGSHIFT_PLAYER_CLOCK_50  in  1  system clock; all state changes on its rising edge.
- SC_REGSHIFT_PLAYER_RESET_InHigh  in  1  reset; synchronous, active-high.
- SC_REGSHIFT_PLAYER_clear_InLow  in  1  0 = reload INIT_POS and zero the counter.
- SC_REGSHIFT_PLAYER_load0_InLow  in  1  0 = load data0_In.
- SC_REGSHIFT_PLAYER_load1_InLow  in  1  0 = load data1_In.
- SC_REGSHIFT_PLAYER_shiftselection_In  in  2  11/00 = hold, 01 = shift left (toward MSB), 10 = shift right.
- SC_REGSHIFT_PLAYER_data0_In  in  DATAWIDTH  load source 0.
- SC_REGSHIFT_PLAYER_data1_In  in  DATAWIDTH  load source 1.
- SC_REGSHIFT_PLAYER_data_Out  out  DATAWIDTH  position register.
- SC_REGSHIFT_PLAYER_sidecomparator_OutLow  out  1  1 = register valid one-hot, moves allowed; 0 = invalid.
- SC_REGSHIFT_PLAYER_atLeft_OutLow  out  1  0 = MSB set.
- SC_REGSHIFT_PLAYER_atRight_OutLow  out  1  0 = LSB set.
- SC_REGSHIFT_PLAYER_bump_OutLow  out  1  registered one-cycle low pulse on a blocked shift.
- SC_REGSHIFT_PLAYER_movecount_Out  out  MOVECOUNT_WIDTH  count of successful shifts.

Behaviour:
- Reset: all state updates on the rising clock edge. RESET_InHigh=1 at an edge gives data=INIT_POS, movecount=0, bump=1. Reset beats every command, including mid-command.
- Command priority per cycle: reset > clear > load0 > load1 > shift > hold. Only the highest-priority active command acts; lower-priority commands that cycle are dropped.
- Latency:
  - data_Out, movecount_Out and bump_OutLow update one cycle after the command is sampled.
  - sidecomparator, atLeft and atRight are combinational from the register, so they are valid in the same cycle the new value appears.
- Shift left:
  - If valid and MSB=0: data <= data<<1 and movecount <= movecount+1 (wraps at 2^MOVECOUNT_WIDTH).
  - If MSB=1: data holds, counter holds, bump_OutLow=0 for exactly one cycle.
- Shift right: mirror of shift left, using LSB and >>1.
- Invalid register (zero or more than one bit set):
  - sidecomparator_OutLow=0.
  - Shifts are ignored: no data change, no count, no bump.
  - Clear and loads still act.
- Loads: the value is taken verbatim, with no validation on load. Invalidity is reported through sidecomparator. Loads do not change movecount.
- Edge flags: atLeft_OutLow = ~data[DATAWIDTH-1]; atRight_OutLow = ~data[0]. Both are computed regardless of validity.
- Holding a shift code for several cycles gives one move per cycle. Rate limiting is the FSM's job (it issues a single shift state per press).
- bump returns to 1 on the next cycle unless another blocked shift is sampled; consecutive blocked shifts keep it low.
- No internal FSM beyond the register, counter and bump flop. All outputs are defined in every cycle with no X.

Decomposition:
- Shared package, also used by the player state machines:
  - SHIFTSEL_HOLD=2'b11, SHIFTSEL_LEFT=2'b01, SHIFTSEL_RIGHT=2'b10, SHIFTSEL_NOP=2'b00.
  - Default DATAWIDTH and INIT_POS constants.
- One natural sub-module, sc_onehot_check: combinational, DATAWIDTH-parameterised, outputs valid, msb and lsb flags. Reused by the opponent's register.

Test Plan:
- Reset: assert reset 2 cycles -> data=8'h10, movecount=0, sidecomparator=1, bump=1. Next cycle, shift=01 -> data=8'h20, movecount=1.
- Left walk to edge:
  - From 8'h10, hold shift=01 for 5 cycles -> 8'h20, 8'h40, 8'h80, then 8'h80 held; movecount=3.
  - atLeft=0 from the 3rd cycle; bump low on cycles 4 and 5.
- Right walk: from 8'h02, shift=10 for 3 cycles -> 8'h01, then hold; movecount+1; bump low for 2 cycles; atRight=0.
- Invalid load:
  - load0=0 with data0=8'h24 -> next cycle data=8'h24, sidecomparator=0.
  - shift=01 -> data unchanged, count unchanged, bump stays 1.
  - clear=0 -> data=8'h10, sidecomparator=1, movecount=0.
- Priority: clear=0, load0=0, load1=0, shift=01 in the same cycle -> data=8'h10. Then load0=0, load1=0 with data0=8'h04, data1=8'h40 -> data=8'h04.
- Counter wrap and reset mid-burst:
  - 16 alternating valid shifts -> movecount wraps to 0.
  - Reset asserted during shift=01 -> data=8'h10, movecount=0.
